mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the pipelined RV32 core.
- Sequences each access through a small FSM and drives stall_f / stall_m for the hazard logic.
- Handles byte loads (sign-extended) and byte stores (byte-enable generation).
- Sits between the pipeline and the memory model/bus; the data side has priority by default.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; used only with ARB_FAIRNESS_EN.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request; held until i_done.
- i_addr  in  ADDR_WIDTH  fetch address, word aligned.
- i_done  out  1  one-cycle pulse: fetch access complete.
- i_rdata  out  32  instruction word, valid with i_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_byte  in  1  byte access (lb/sb), else word.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  32  store data; the byte is in bits [7:0] when d_byte=1.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load result (sign-extended byte or word), valid with d_done.
- mem_req  out  1  memory request, registered, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word address; bits [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data, byte replicated into all lanes when d_byte=1.
- mem_ack  in  1  memory completion pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read data.
- stall_f  out  1  i_req & ~i_done.
- stall_m  out  1  d_req & ~d_done.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, i_done=0, d_done=0, starvation counter=0.
- IDLE:
  - d_req=1 → BUSY_D. Latch d_addr, d_we, d_byte, d_wdata and addr[1:0] into the memory-side registers.
  - else i_req=1 → BUSY_I. Latch i_addr; mem_be=4'b1111; mem_we=0.
  - else stay in IDLE.
  - mem_req rises on the cycle after the grant decision; minimum request-to-mem_req latency is 1 cycle.
- BUSY_x: mem_req=1 and all memory-side outputs stable until mem_ack.
- On mem_ack in BUSY_x:
  - x_done=1 in the same cycle (combinational from mem_ack & state).
  - rdata output is driven from mem_rdata in the same cycle.
  - Next state is IDLE; mem_req=0 next cycle.
  - Total latency = 1 + memory latency; a back-to-back request on the other side costs one IDLE cycle.
- Byte loads: select byte mem_rdata[8*a+7:8*a] using latched addr[1:0]=a, sign-extend to 32 bits.
- Byte stores: mem_be = 1<<a; mem_wdata = {4{d_wdata[7:0]}}.
- Word access: mem_be=4'b1111, data passed straight through; d_addr[1:0] is ignored (no misalignment trap).
- i_rdata and d_rdata are 0 when the corresponding done is low.
- Requester rule: the cycle after done, req may stay high only for a new request (new address/attributes). The arbiter treats it as a fresh request in IDLE.
- Simultaneous i_req and d_req in IDLE: data wins; fetch stalls (stall_f=1) until its own i_done.
- mem_ack in IDLE is ignored, with no done pulse. This covers a stray ack after reset.
- Reset mid-access: state→IDLE and mem_req→0 on the next edge; the in-flight access is abandoned and no done is issued.
- Requester dropping req while in BUSY is illegal; the access completes anyway and done still pulses.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A counter increments on each data grant made while i_req=1.
  - The counter clears on any fetch grant, or when i_req=0 at a grant decision.
  - When counter == STARVE_LIMIT and both requests are pending in IDLE, fetch is granted instead.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Memory latency 2, i_req only, i_addr=0x40, mem_rdata=0x00500093 → mem_req at cycle+1, mem_addr=0x40, mem_be=4'hF; i_done at cycle+3 with i_rdata=0x00500093; stall_f high until then.
- i_req and d_req together, d_we=1, d_addr=0x104, d_wdata=0xDEADBEEF → data served first (mem_we=1, mem_be=4'hF); fetch is granted the cycle after d_done.
- Byte load, d_addr=0x203, mem_rdata=0x80112233 → d_rdata=0xFFFFFF80. Same with d_addr=0x201 → 0x00000022.
- Byte store, d_addr=0x302, d_wdata=0x000000AB → mem_addr=0x300, mem_be=4'b0100, mem_wdata=0xABABABAB.
- reset asserted mid-BUSY_D, then mem_ack arrives → mem_req=0 after the reset edge; no d_done; state IDLE.
- ARB_FAIRNESS_EN, STARVE_LIMIT=4, d_req held continuously with new accesses plus i_req high → exactly 4 data grants, then 1 fetch grant, then data resumes.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports plus the shared memory bus.
// slave is the arbiter's view; master is the pipeline-and-memory view.
interface mem_port_arbiter_if #(parameter int ADDR_WIDTH = 32);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_done;
    logic [31:0]           i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic                  d_byte;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic                  d_done;
    logic [31:0]           d_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;
    logic                  stall_f;
    logic                  stall_m;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_be,
               mem_wdata, stall_f, stall_m
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_be,
               mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first.
// Define ARB_FAIRNESS_EN to grant fetch after STARVE_LIMIT data grants while it waits.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t      state, state_n;
    logic        grant_d, grant_i, fair_fetch;
    logic        lat_byte;
    logic [1:0]  lat_a;
    logic [31:0] shifted;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    always_comb begin
        state_n = state;
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = bus.d_req & ~fair_fetch;
            grant_i = bus.i_req & ~grant_d;
            state_n = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
        end else if (bus.mem_ack) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= 4'b0000;
            bus.mem_wdata <= '0;
            lat_byte      <= 1'b0;
            lat_a         <= 2'b00;
        end else begin
            state       <= state_n;
            bus.mem_req <= state_n != IDLE;
            if (grant_d) begin
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr & ~ADDR_WIDTH'(3);
                bus.mem_be    <= bus.d_byte ? 4'b0001 << bus.d_addr[1:0] : 4'b1111;
                bus.mem_wdata <= bus.d_byte ? {4{bus.d_wdata[7:0]}} : bus.d_wdata;
                lat_byte      <= bus.d_byte;
                lat_a         <= bus.d_addr[1:0];
            end else if (grant_i) begin
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= bus.i_addr & ~ADDR_WIDTH'(3);
                bus.mem_be   <= 4'b1111;
            end
        end
    end

    // Completion is combinational so the requester sees data in the ack cycle.
    assign bus.i_done  = state == BUSY_I && bus.mem_ack;
    assign bus.d_done  = state == BUSY_D && bus.mem_ack;
    assign shifted     = bus.mem_rdata >> {lat_a, 3'b000};
    assign bus.i_rdata = bus.i_done ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata = !bus.d_done ? 32'h0 :
                         lat_byte ? {{24{shifted[7]}}, shifted[7:0]} : bus.mem_rdata;
    assign bus.stall_f = bus.i_req & ~bus.i_done;
    assign bus.stall_m = bus.d_req & ~bus.d_done;

`ifdef ARB_FAIRNESS_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve;

    assign fair_fetch = bus.i_req && starve == CW'(STARVE_LIMIT);

    always_ff @(posedge clk) begin
        if (reset || grant_i || (grant_d && !bus.i_req))
            starve <= '0;
        else if (grant_d)
            starve <= starve + 1'b1;
    end
`else
    assign fair_fetch = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, byte lanes, latency and reset abort.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus();

    mem_port_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic ack(input logic [31:0] data);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        #1;
    endtask

    task automatic release_all();
        tick();
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_byte  = 1'b0;
        #1;
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_byte = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;

        ack(32'h1234_5678);
        chk("stray_i_done", 32'(bus.i_done), 32'h0);
        chk("stray_d_done", 32'(bus.d_done), 32'h0);
        chk("stray_d_rdata", bus.d_rdata, 32'h0);
        release_all();
        chk("stray_mem_req", 32'(bus.mem_req), 32'h0);

        bus.i_req = 1'b1; bus.i_addr = 32'h40; #1;
        chk("f_stall0", 32'(bus.stall_f), 32'h1);
        tick();
        chk("f_mem_req", 32'(bus.mem_req), 32'h1);
        chk("f_mem_addr", bus.mem_addr, 32'h40);
        chk("f_mem_be", 32'(bus.mem_be), 32'hF);
        chk("f_mem_we", 32'(bus.mem_we), 32'h0);
        tick();
        chk("f_wait_done", 32'(bus.i_done), 32'h0);
        chk("f_wait_stall", 32'(bus.stall_f), 32'h1);
        tick();
        ack(32'h0050_0093);
        chk("f_done", 32'(bus.i_done), 32'h1);
        chk("f_rdata", bus.i_rdata, 32'h0050_0093);
        chk("f_stall_off", 32'(bus.stall_f), 32'h0);
        release_all();
        chk("f_req_drop", 32'(bus.mem_req), 32'h0);
        chk("f_rdata_idle", bus.i_rdata, 32'h0);

        bus.i_req = 1; bus.i_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h104; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("pri_mem_we", 32'(bus.mem_we), 32'h1);
        chk("pri_mem_addr", bus.mem_addr, 32'h104);
        chk("pri_mem_be", 32'(bus.mem_be), 32'hF);
        chk("pri_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("pri_stall_f", 32'(bus.stall_f), 32'h1);
        ack(32'h0);
        chk("pri_d_done", 32'(bus.d_done), 32'h1);
        chk("pri_i_done", 32'(bus.i_done), 32'h0);
        chk("pri_stall_m", 32'(bus.stall_m), 32'h0);
        tick();
        bus.mem_ack = 0; bus.d_req = 0; bus.d_we = 0; #1;
        chk("pri_idle_gap", 32'(bus.mem_req), 32'h0);
        tick();
        chk("pri_fetch_req", 32'(bus.mem_req), 32'h1);
        chk("pri_fetch_addr", bus.mem_addr, 32'h80);
        chk("pri_fetch_we", 32'(bus.mem_we), 32'h0);
        ack(32'h0000_0013);
        chk("pri_fetch_rdata", bus.i_rdata, 32'h0000_0013);
        release_all();

        bus.d_req = 1; bus.d_we = 0; bus.d_byte = 1; bus.d_addr = 32'h203;
        tick();
        chk("lb3_addr", bus.mem_addr, 32'h200);
        chk("lb3_be", 32'(bus.mem_be), 32'h8);
        ack(32'h8011_2233);
        chk("lb3_rdata", bus.d_rdata, 32'hFFFF_FF80);
        tick();
        bus.mem_ack = 0; bus.d_addr = 32'h201; #1;
        tick();
        chk("lb1_be", 32'(bus.mem_be), 32'h2);
        ack(32'h8011_2233);
        chk("lb1_rdata", bus.d_rdata, 32'h0000_0022);
        release_all();

        bus.d_req = 1; bus.d_we = 1; bus.d_byte = 1; bus.d_addr = 32'h302; bus.d_wdata = 32'hAB;
        tick();
        chk("sb_addr", bus.mem_addr, 32'h300);
        chk("sb_be", 32'(bus.mem_be), 32'h4);
        chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        chk("sb_we", 32'(bus.mem_we), 32'h1);
        ack(32'h0);
        chk("sb_done", 32'(bus.d_done), 32'h1);
        release_all();

        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h207;
        tick();
        chk("lw_addr", bus.mem_addr, 32'h204);
        chk("lw_be", 32'(bus.mem_be), 32'hF);
        ack(32'h8011_2233);
        chk("lw_rdata", bus.d_rdata, 32'h8011_2233);
        release_all();

        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
        tick();
        chk("rb_busy", 32'(bus.mem_req), 32'h1);
        reset = 1'b1;
        tick();
        chk("rb_req_drop", 32'(bus.mem_req), 32'h0);
        reset = 1'b0; bus.d_req = 0;
        ack(32'h5555_5555);
        chk("rb_no_done", 32'(bus.d_done), 32'h0);
        chk("rb_no_rdata", bus.d_rdata, 32'h0);
        release_all();
        chk("rb_idle", 32'(bus.mem_req), 32'h0);

        bus.i_req = 1; bus.i_addr = 32'h600; bus.d_we = 1;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_addr;
            bus.d_req = 1; bus.d_addr = 32'h500 + 32'(4 * k);
`ifdef ARB_FAIRNESS_EN
            exp_addr = (k == 4) ? 32'h600 : 32'h500 + 32'(4 * k);
`else
            exp_addr = 32'h500 + 32'(4 * k);
`endif
            tick();
            chk($sformatf("fair_grant%0d", k), bus.mem_addr, exp_addr);
            ack(32'h0);
            tick();
            bus.mem_ack = 0; #1;
        end
        bus.d_req = 0; #1;
        tick();
        chk("fair_fetch_last", bus.mem_addr, 32'h600);
        ack(32'h0);
        release_all();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
